// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal step/dir sequencer: issues step_count pulses, ramping the step
// period from period_start down to period_min and back up before the end.
module stepper_ramp_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int PER_WIDTH   = 16,
  parameter int PULSE_WIDTH = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dir_in,
  input  logic [CNT_WIDTH-1:0] step_count,
  input  logic [PER_WIDTH-1:0] period_start,
  input  logic [PER_WIDTH-1:0] period_min,
  input  logic [PER_WIDTH-1:0] period_delta,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] steps_done
);
  // A period must leave at least one low cycle after the pulse.
  localparam logic [PER_WIDTH-1:0] PER_FLOOR = PER_WIDTH'(PULSE_WIDTH + 1);
  localparam logic [PER_WIDTH-1:0] HI_LOAD   = PER_WIDTH'(PULSE_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, FINISH} state_t;

  state_t               state_reg, state_next;
  logic [PER_WIDTH-1:0] cur_reg, cur_next, pmin_reg, pmin_next;
  logic [PER_WIDTH-1:0] pstart_reg, pstart_next, delta_reg, delta_next;
  logic [PER_WIDTH-1:0] timer_reg, timer_next, hi_reg, hi_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next, accel_reg, accel_next;
  logic [CNT_WIDTH-1:0] steps_reg, steps_next;
  logic                 step_reg, step_next, dir_reg, dir_next;
  logic                 busy_reg, busy_next, done_reg, done_next;
  logic                 aborted_reg, aborted_next;

  logic [PER_WIDTH-1:0] pmin_eff, cur_eff, cur_up, cur_down;
  logic [PER_WIDTH:0]   up_sum;
  logic [CNT_WIDTH-1:0] rem;

  always_comb begin
    pmin_eff = (period_min > PER_FLOOR) ? period_min : PER_FLOOR;
    cur_eff  = (period_start > pmin_eff) ? period_start : pmin_eff;
    up_sum   = {1'b0, cur_reg} + {1'b0, delta_reg};
    cur_up   = (up_sum > {1'b0, pstart_reg}) ? pstart_reg : up_sum[PER_WIDTH-1:0];
    cur_down = (delta_reg >= cur_reg - pmin_reg) ? pmin_reg : cur_reg - delta_reg;
    rem      = count_reg - steps_reg;
  end

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    pmin_next    = pmin_reg;
    pstart_next  = pstart_reg;
    delta_next   = delta_reg;
    count_next   = count_reg;
    accel_next   = accel_reg;
    steps_next   = steps_reg;
    dir_next     = dir_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    aborted_next = aborted_reg;
    timer_next   = (timer_reg != '0) ? timer_reg - 1'b1 : timer_reg;
    hi_next      = hi_reg;
    step_next    = step_reg;
    if (step_reg) begin
      if (hi_reg == '0) step_next = 1'b0;
      else              hi_next   = hi_reg - 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (abort) begin
          aborted_next = 1'b1;
        end else if (start) begin
          pmin_next    = pmin_eff;
          cur_next     = cur_eff;
          pstart_next  = cur_eff;
          delta_next   = period_delta;
          count_next   = step_count;
          accel_next   = '0;
          dir_next     = dir_in;
          aborted_next = 1'b0;
          busy_next    = 1'b1;
          if (step_count == '0) begin
            // Empty move: one busy cycle at a step boundary with nothing left.
            state_next = CRUISE;
            timer_next = '0;
            steps_next = '0;
          end else begin
            state_next = (cur_eff > pmin_eff) ? ACCEL : CRUISE;
            timer_next = cur_eff - 1'b1;
            step_next  = 1'b1;
            hi_next    = HI_LOAD;
            steps_next = CNT_WIDTH'(1);
          end
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (timer_reg == '0) begin
          if (rem == '0) begin
            state_next = FINISH;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            step_next  = 1'b1;
            hi_next    = HI_LOAD;
            steps_next = steps_reg + 1'b1;
            if (state_reg == DECEL) begin
              cur_next = cur_up;
            end else if (rem <= accel_reg) begin
              state_next = DECEL;
              cur_next   = cur_up;
            end else if (state_reg == ACCEL) begin
              cur_next   = cur_down;
              accel_next = accel_reg + 1'b1;
              if (cur_down == pmin_reg) state_next = CRUISE;
            end
            timer_next = cur_next - 1'b1;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort && state_reg != IDLE) begin
      state_next   = IDLE;
      step_next    = 1'b0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      aborted_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      pmin_reg    <= '0;
      pstart_reg  <= '0;
      delta_reg   <= '0;
      count_reg   <= '0;
      accel_reg   <= '0;
      steps_reg   <= '0;
      timer_reg   <= '0;
      hi_reg      <= '0;
      step_reg    <= 1'b0;
      dir_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      pmin_reg    <= pmin_next;
      pstart_reg  <= pstart_next;
      delta_reg   <= delta_next;
      count_reg   <= count_next;
      accel_reg   <= accel_next;
      steps_reg   <= steps_next;
      timer_reg   <= timer_next;
      hi_reg      <= hi_next;
      step_reg    <= step_next;
      dir_reg     <= dir_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  assign step_out   = step_reg;
  assign dir_out    = dir_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign aborted    = aborted_reg;
  assign steps_done = steps_reg;
endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Bench for stepper_ramp_ctrl: step-level profile model, per-move waveform
// measurement (rise cycles, pulse widths, busy span, done cycle).
module tb_stepper_ramp_ctrl;
  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort, dir_in;
  logic [15:0] step_count, period_start, period_min, period_delta;
  logic        step_out, dir_out, busy, done, aborted;
  logic [15:0] steps_done;

  int errors = 0;
  int checks = 0;
  int exp_per[$];

  stepper_ramp_ctrl #(.CNT_WIDTH(16), .PER_WIDTH(16), .PULSE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dir_in(dir_in),
    .step_count(step_count), .period_start(period_start), .period_min(period_min),
    .period_delta(period_delta), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .done(done), .aborted(aborted), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  // Step-by-step list of periods from the ramp rules (phase 0 accel, 1 cruise, 2 decel).
  function automatic void build_profile(input int n, input int ps, input int pm, input int d);
    int pme, cur, pse, phase, acc, rem;
    exp_per.delete();
    pme   = (pm > PW + 1) ? pm : PW + 1;
    cur   = (ps > pme) ? ps : pme;
    pse   = cur;
    phase = (cur > pme) ? 0 : 1;
    acc   = 0;
    for (int k = 1; k <= n; k++) begin
      exp_per.push_back(cur);
      rem = n - k;
      if (rem == 0) break;
      if (phase == 2) begin
        cur = (cur + d < pse) ? cur + d : pse;
      end else if (rem <= acc) begin
        phase = 2;
        cur = (cur + d < pse) ? cur + d : pse;
      end else if (phase == 0) begin
        cur = (cur - d > pme) ? cur - d : pme;
        acc++;
        if (cur == pme) phase = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input int ps, input int pm, input int d, input bit dr);
    step_count   = 16'(n);
    period_start = 16'(ps);
    period_min   = 16'(pm);
    period_delta = 16'(d);
    dir_in       = dr;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    step_count   = 16'($urandom);
    period_start = 16'($urandom);
    period_min   = 16'($urandom);
    period_delta = 16'($urandom);
    dir_in       = ~dr;
  endtask

  task automatic run_move(input string name, input int n, input int ps, input int pm,
                          input int d, input bit dr, input int inject);
    int rises[$];
    int widths[$];
    int total, done_c, busy_cnt, exp_done, exp_rise, lim;
    bit prev;
    build_profile(n, ps, pm, d);
    total = 0;
    foreach (exp_per[i]) total += exp_per[i];
    exp_done = (n == 0) ? 2 : total + 1;
    do_start(n, ps, pm, d, dr);
    done_c = -1; busy_cnt = 0; prev = 1'b0;
    for (int c = 1; c <= total + 30; c++) begin
      if (step_out && !prev) begin
        rises.push_back(c);
        widths.push_back(1);
      end else if (step_out) begin
        widths[widths.size()-1]++;
      end
      prev = step_out;
      if (busy) busy_cnt++;
      if (done) begin
        done_c = c;
        break;
      end
      start = (c == inject);
      tick();
    end
    start = 1'b0;

    checks++;
    if (done_c !== exp_done) begin
      errors++;
      $display("FAIL %s done_cycle got %0d expected %0d", name, done_c, exp_done);
    end
    checks++;
    if (rises.size() !== exp_per.size()) begin
      errors++;
      $display("FAIL %s pulse_count got %0d expected %0d", name, rises.size(), exp_per.size());
    end
    lim = (rises.size() < exp_per.size()) ? rises.size() : exp_per.size();
    exp_rise = 1;
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (rises[i] !== exp_rise) begin
        errors++;
        $display("FAIL %s rise[%0d] got %0d expected %0d", name, i, rises[i], exp_rise);
      end
      checks++;
      if (widths[i] !== PW) begin
        errors++;
        $display("FAIL %s width[%0d] got %0d expected %0d", name, i, widths[i], PW);
      end
      exp_rise += exp_per[i];
    end
    checks++;
    if (busy_cnt !== ((n == 0) ? 1 : total)) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected %0d", name, busy_cnt, (n == 0) ? 1 : total);
    end
    checks++;
    if (steps_done !== 16'(n) || busy !== 1'b0 || aborted !== 1'b0 || dir_out !== dr) begin
      errors++;
      $display("FAIL %s final steps_done=%0d busy=%b aborted=%b dir=%b expected %0d 0 0 %b",
               name, steps_done, busy, aborted, dir_out, n, dr);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width got done=%b one cycle later expected 0", name, done);
    end
    $display("move %s n=%0d ps=%0d pm=%0d d=%0d dir=%0b total=%0d done_cycle=%0d pulses=%0d",
             name, n, ps, pm, d, dr, total, done_c, rises.size());
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
    step_count = '0; period_start = '0; period_min = '0; period_delta = '0;
    repeat (3) tick();
    checks++;
    if ({step_out, dir_out, busy, done, aborted} !== 5'b0 || steps_done !== 16'd0) begin
      errors++;
      $display("FAIL reset outputs got %b%b%b%b%b steps=%0d expected all 0",
               step_out, dir_out, busy, done, aborted, steps_done);
    end
    reset = 1'b0;
    tick();
    $display("reset checked");
  endtask

  task automatic test_abort();
    bit saw_done;
    do_start(10, 20, 10, 5, 1'b0);
    repeat (47) tick();
    checks++;
    if (step_out !== 1'b1) begin
      errors++;
      $display("FAIL abort pre_step_out got %b expected 1", step_out);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (step_out !== 1'b0 || busy !== 1'b0 || aborted !== 1'b1 || steps_done !== 16'd4 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort state got step=%b busy=%b aborted=%b steps=%0d done=%b expected 0 0 1 4 0",
               step_out, busy, aborted, steps_done, done);
    end
    saw_done = 1'b0;
    repeat (100) begin
      tick();
      if (done || step_out) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || steps_done !== 16'd4) begin
      errors++;
      $display("FAIL abort quiet got activity=%b steps=%0d expected 0 4", saw_done, steps_done);
    end
    $display("abort mid-move steps_done=%0d aborted=%b", steps_done, aborted);
    start = 1'b1; abort = 1'b1; step_count = 16'd5;
    period_start = 16'd10; period_min = 16'd10; period_delta = 16'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || step_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_start got busy=%b aborted=%b step=%b expected 0 1 0", busy, aborted, step_out);
    end
    $display("start+abort in idle busy=%b aborted=%b", busy, aborted);
    run_move("after_abort", 6, 20, 10, 5, 1'b1, -1);
  endtask

  task automatic test_reset_mid_move();
    bit saw_done;
    do_start(10, 20, 10, 5, 1'b1);
    repeat (46) tick();
    checks++;
    if (step_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre got step=%b busy=%b expected 1 1", step_out, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (step_out !== 1'b0 || busy !== 1'b0 || steps_done !== 16'd0 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset post got step=%b busy=%b steps=%0d dir=%b expected 0 0 0 0",
               step_out, busy, steps_done, dir_out);
    end
    saw_done = 1'b0;
    repeat (150) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midreset done got pulse expected none");
    end
    $display("reset mid-move step_out=%b busy=%b steps_done=%0d", step_out, busy, steps_done);
  endtask

  task automatic test_random();
    int n, ps, pm, d, inj;
    for (int i = 0; i < 25; i++) begin
      n   = $urandom_range(0, 12);
      ps  = $urandom_range(2, 30);
      pm  = $urandom_range(2, 20);
      d   = $urandom_range(0, 8);
      inj = ($urandom_range(0, 1) == 1 && n > 0) ? $urandom_range(2, 5 * n) : -1;
      run_move($sformatf("rand%0d", i), n, ps, pm, d, 1'($urandom_range(0, 1)), inj);
    end
  endtask

  initial begin
    abort = 1'b0;
    start = 1'b0;
    reset = 1'b0;
    test_reset();
    run_move("fixed_cruise", 3, 10, 10, 0, 1'b1, -1);
    run_move("trapezoid", 10, 20, 10, 5, 1'b0, -1);
    run_move("triangle", 3, 20, 10, 5, 1'b1, -1);
    run_move("even_ramp", 4, 20, 5, 5, 1'b0, -1);
    run_move("zero_count", 0, 20, 10, 5, 1'b1, -1);
    run_move("clamp", 4, 3, 2, 1, 1'b0, -1);
    run_move("delta_zero_ramp", 5, 12, 6, 0, 1'b1, -1);
    run_move("start_while_busy", 10, 20, 10, 5, 1'b1, 40);
    test_abort();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
